// File: rtl/jtag_bitbang_master_if.sv
// Command/response bundle between a JTAG scan requester and jtag_bitbang_master.
// The requester uses the master view; the bit-bang engine uses the slave view.
interface jtag_bitbang_master_if #(
   parameter int MAX_LEN = 40
);
   logic               cmd_valid;
   logic               cmd_ready;
   logic [1:0]         cmd_op;
   logic [5:0]         cmd_len;
   logic [MAX_LEN-1:0] cmd_data;
   logic               rsp_valid;
   logic               rsp_err;
   logic [MAX_LEN-1:0] rsp_data;
   logic               busy;

   modport master (
      output cmd_valid, cmd_op, cmd_len, cmd_data,
      input  cmd_ready, rsp_valid, rsp_err, rsp_data, busy
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_len, cmd_data,
      output cmd_ready, rsp_valid, rsp_err, rsp_data, busy
   );
endinterface

// File: rtl/jtag_bitbang_master.sv
// JTAG host: each command (TAP reset, IR scan, DR scan) is played out as a series of
// TCK steps whose TMS/TDI come from a per-op schedule indexed by the step counter.
module jtag_bitbang_master #(
   parameter int DIV          = 5,
   parameter int MAX_LEN      = 40,
   parameter int RESET_CYCLES = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   jtag_bitbang_master_if.slave bus,
   output logic                 jtag_TCK,
   output logic                 jtag_TMS,
   output logic                 jtag_TDI,
   input  logic                 jtag_TDO
);
   localparam int MAX_STEPS = (MAX_LEN + 6 > RESET_CYCLES + 1) ? MAX_LEN + 6 : RESET_CYCLES + 1;
   localparam int STEP_W    = $clog2(MAX_STEPS + 1);
   localparam int CNT_W     = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

   localparam logic [1:0] OP_RESET = 2'b00;
   localparam logic [1:0] OP_IR    = 2'b01;
   localparam logic [1:0] OP_DR    = 2'b10;

   typedef enum logic [2:0] {IDLE, STEP_LO, STEP_HI, DONE, ERR} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [STEP_W-1:0]  step_q, step_d;
   logic [MAX_LEN-1:0] cap_q, cap_d;
   logic               tck_q, tck_d;
   logic               tms_q, tms_d;
   logic               tdi_q, tdi_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic               rsp_err_q, rsp_err_d;
   logic [1:0]         op_q;
   logic [5:0]         len_q;
   logic [MAX_LEN-1:0] data_q;
   logic               load;

   // Steps before the first shift step: SelDR,SelIR,CapIR,ShiftIR or SelDR,CapDR,ShiftDR.
   function automatic logic [STEP_W-1:0] pre_steps(input logic [1:0] op);
      return (op == OP_IR) ? STEP_W'(4) : STEP_W'(3);
   endfunction

   function automatic logic [STEP_W-1:0] last_shift(input logic [1:0] op, input logic [5:0] len);
      return pre_steps(op) + STEP_W'(len) - STEP_W'(1);
   endfunction

   function automatic logic [STEP_W-1:0] last_step(input logic [1:0] op, input logic [5:0] len);
      if (op == OP_RESET) return STEP_W'(RESET_CYCLES);
      return last_shift(op, len) + STEP_W'(2);
   endfunction

   function automatic logic in_shift(input logic [1:0] op, input logic [5:0] len,
                                     input logic [STEP_W-1:0] s);
      return (op != OP_RESET) && (s >= pre_steps(op)) && (s <= last_shift(op, len));
   endfunction

   function automatic logic step_tms(input logic [1:0] op, input logic [5:0] len,
                                     input logic [STEP_W-1:0] s);
      if (op == OP_RESET) return s < STEP_W'(RESET_CYCLES);
      if (s == '0) return 1'b1;
      if (s < pre_steps(op)) return (op == OP_IR) && (s == STEP_W'(1));
      if (s <= last_shift(op, len)) return s == last_shift(op, len);
      return s == last_shift(op, len) + STEP_W'(1);
   endfunction

   function automatic logic step_tdi(input logic [1:0] op, input logic [5:0] len,
                                     input logic [MAX_LEN-1:0] data, input logic [STEP_W-1:0] s);
      logic [MAX_LEN-1:0] shifted;
      shifted = data >> (s - pre_steps(op));
      return in_shift(op, len, s) ? shifted[0] : 1'b1;
   endfunction

   function automatic logic cmd_bad(input logic [1:0] op, input logic [5:0] len);
      return (op == 2'b11) || ((op != OP_RESET) && ((len == 6'd0) || (int'(len) > MAX_LEN)));
   endfunction

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      step_d      = step_q;
      cap_d       = cap_q;
      tck_d       = tck_q;
      tms_d       = tms_q;
      tdi_d       = tdi_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      load        = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.cmd_valid) begin
               load   = 1'b1;
               cap_d  = '0;
               cnt_d  = '0;
               step_d = '0;
               if (cmd_bad(bus.cmd_op, bus.cmd_len)) begin
                  state_d = ERR;
               end else begin
                  state_d = STEP_LO;
                  tms_d   = step_tms(bus.cmd_op, bus.cmd_len, '0);
                  tdi_d   = step_tdi(bus.cmd_op, bus.cmd_len, bus.cmd_data, '0);
               end
            end
         end
         STEP_LO: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               tck_d   = 1'b1;
               state_d = STEP_HI;
               // TDO is taken on the final low-phase clk, just before TCK rises.
               if (in_shift(op_q, len_q, step_q))
                  cap_d = cap_q | (MAX_LEN'(jtag_TDO) << (step_q - pre_steps(op_q)));
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         STEP_HI: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               tck_d = 1'b0;
               if (step_q == last_step(op_q, len_q)) begin
                  state_d = DONE;
               end else begin
                  state_d = STEP_LO;
                  step_d  = step_q + STEP_W'(1);
                  tms_d   = step_tms(op_q, len_q, step_q + STEP_W'(1));
                  tdi_d   = step_tdi(op_q, len_q, data_q, step_q + STEP_W'(1));
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            rsp_valid_d = 1'b1;
            state_d     = IDLE;
         end
         ERR: begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         step_q      <= '0;
         cap_q       <= '0;
         tck_q       <= 1'b0;
         tms_q       <= 1'b1;
         tdi_q       <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         step_q      <= step_d;
         cap_q       <= cap_d;
         tck_q       <= tck_d;
         tms_q       <= tms_d;
         tdi_q       <= tdi_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // Command fields are frozen at acceptance so the requester may change them freely.
   always_ff @(posedge clk) begin
      if (load) begin
         op_q   <= bus.cmd_op;
         len_q  <= bus.cmd_len;
         data_q <= bus.cmd_data;
      end
   end

   assign bus.cmd_ready = (state_q == IDLE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_data  = cap_q;
   assign jtag_TCK      = tck_q;
   assign jtag_TMS      = tms_q;
   assign jtag_TDI      = tdi_q;
endmodule

// File: tb/tb_jtag_bitbang_master.sv
// Scoreboard bench for jtag_bitbang_master: expected TMS/TDI per TCK edge and expected
// responses are built from the scan rules and compared by independent monitors.
module tb_jtag_bitbang_master;
   localparam int DIV     = 2;
   localparam int MAX_LEN = 40;
   localparam int RC      = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic jtag_TCK, jtag_TMS, jtag_TDI, jtag_TDO;

   jtag_bitbang_master_if #(.MAX_LEN(MAX_LEN)) bus();

   jtag_bitbang_master #(.DIV(DIV), .MAX_LEN(MAX_LEN), .RESET_CYCLES(RC)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .jtag_TCK(jtag_TCK), .jtag_TMS(jtag_TMS), .jtag_TDI(jtag_TDI), .jtag_TDO(jtag_TDO)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Target model: a one-bit shift stage (TDI captured on TCK rise, presented on TCK fall).
   logic tdo_dev = 1'b1, tdo_out = 1'b1, tdo_inv = 1'b0, tdo_const = 1'b0;
   always @(posedge jtag_TCK) tdo_dev <= jtag_TDI;
   always @(negedge jtag_TCK) tdo_out <= tdo_dev;
   assign jtag_TDO = tdo_const ? 1'b1 : (tdo_out ^ tdo_inv);

   typedef struct { logic err; logic [MAX_LEN-1:0] data; int lat; int acc; } rsp_t;
   typedef struct { logic tms; logic tdi; } edge_t;
   rsp_t  rsp_q[$];
   edge_t edge_q[$];
   int    rise_cyc[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   function automatic logic [MAX_LEN-1:0] rand40();
      return {8'($urandom), 32'($urandom)};
   endfunction

   task automatic push_edge(input logic tms, input logic tdi);
      edge_t e;
      e.tms = tms;
      e.tdi = tdi;
      edge_q.push_back(e);
   endtask

   // Reference: TAP path lists and expected capture for one accepted command.
   task automatic expect_cmd(input logic [1:0] op, input int len, input logic [MAX_LEN-1:0] d,
                             input logic inv, input logic konst, input int acc);
      rsp_t r;
      int   steps;
      logic prev;
      r.acc  = acc;
      r.data = '0;
      r.err  = 1'b0;
      if (op == 2'b11 || (op != 2'b00 && (len < 1 || len > MAX_LEN))) begin
         r.err = 1'b1;
         r.lat = 1;
         rsp_q.push_back(r);
         return;
      end
      if (op == 2'b00) begin
         for (int i = 0; i < RC; i++) push_edge(1'b1, 1'b1);
         push_edge(1'b0, 1'b1);
         steps = RC + 1;
      end else begin
         push_edge(1'b1, 1'b1);
         if (op == 2'b01) push_edge(1'b1, 1'b1);
         push_edge(1'b0, 1'b1);
         push_edge(1'b0, 1'b1);
         prev = 1'b1;
         for (int k = 0; k < len; k++) begin
            push_edge(k == len - 1, d[k]);
            r.data[k] = konst ? 1'b1 : (prev ^ inv);
            prev = d[k];
         end
         push_edge(1'b1, 1'b1);
         push_edge(1'b0, 1'b1);
         steps = ((op == 2'b01) ? 6 : 5) + len;
      end
      r.lat = steps * 2 * DIV + 1;
      rsp_q.push_back(r);
   endtask

   // Called at a negedge; returns at the negedge after the accepting posedge.
   task automatic issue(input logic [1:0] op, input int len, input logic [MAX_LEN-1:0] d,
                        input logic inv, input logic konst, input bit hold);
      int n = 0;
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_len   = 6'(len);
      bus.cmd_data  = d;
      while (bus.cmd_ready !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) begin
         fail_now("accept_timeout");
         bus.cmd_valid = 1'b0;
         return;
      end
      tdo_inv   = inv;
      tdo_const = konst;
      expect_cmd(op, len, d, inv, konst, cyc + 1);
      @(negedge clk);
      if (!hold) begin
         bus.cmd_valid = 1'b0;
         bus.cmd_op    = 2'($urandom);
         bus.cmd_len   = 6'($urandom);
         bus.cmd_data  = rand40();
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((rsp_q.size() != 0 || bus.cmd_ready !== 1'b1) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) fail_now("idle_timeout");
      @(negedge clk);
   endtask

   // Response monitor.
   always @(negedge clk) begin
      rsp_t r;
      if (bus.rsp_valid === 1'b1) begin
         if (rsp_q.size() == 0) begin
            fail_now("unexpected_rsp_valid");
         end else begin
            r = rsp_q.pop_front();
            chk("rsp_err", 64'(bus.rsp_err), 64'(r.err));
            chk("rsp_data", 64'(bus.rsp_data), 64'(r.data));
            chk("rsp_latency", 64'(cyc - r.acc), 64'(r.lat));
         end
      end
   end

   // TCK edge monitor: TMS/TDI are stable through the high phase.
   logic tck_prev = 1'b0;
   always @(negedge clk) begin
      edge_t e;
      if (jtag_TCK === 1'b1 && tck_prev === 1'b0) begin
         rise_cyc.push_back(cyc);
         if (edge_q.size() == 0) begin
            fail_now("unexpected_tck_edge");
         end else begin
            e = edge_q.pop_front();
            chk("tms_edge", 64'(jtag_TMS), 64'(e.tms));
            chk("tdi_edge", 64'(jtag_TDI), 64'(e.tdi));
         end
      end
      tck_prev <= jtag_TCK;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [MAX_LEN-1:0] d;
      logic [1:0]         op;
      int                 len, n, n0;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'b00;
      bus.cmd_len   = 6'd0;
      bus.cmd_data  = '0;
      repeat (3) @(negedge clk);
      chk("rst_tck", 64'(jtag_TCK), 64'd0);
      chk("rst_tms", 64'(jtag_TMS), 64'd1);
      chk("rst_tdi", 64'(jtag_TDI), 64'd1);
      chk("rst_ready", 64'(bus.cmd_ready), 64'd1);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
      chk("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
      rst = 1'b1;
      @(negedge clk);

      // TAP reset, then IR len 5 with TDO tied high.
      issue(2'b00, 0, '0, 1'b0, 1'b0, 1'b0);
      wait_idle();
      issue(2'b01, 5, 40'h11, 1'b0, 1'b1, 1'b0);
      wait_idle();

      // Debug-module style access sequence.
      issue(2'b00, 0, rand40(), 1'b0, 1'b0, 1'b0);
      issue(2'b01, 5, 40'h11, 1'b1, 1'b0, 1'b0);
      issue(2'b10, 40, {6'h10, 32'h0, 2'b10}, 1'b0, 1'b0, 1'b0);
      issue(2'b10, 40, {6'h11, 32'h0, 2'b01}, 1'b1, 1'b0, 1'b0);
      wait_idle();

      // Rejected commands never toggle TCK.
      n0 = rise_cyc.size();
      issue(2'b01, 0, rand40(), 1'b0, 1'b0, 1'b0);
      issue(2'b10, 41, rand40(), 1'b0, 1'b0, 1'b0);
      issue(2'b11, 8, rand40(), 1'b0, 1'b0, 1'b0);
      wait_idle();
      chk("no_tck_on_reject", 64'(rise_cyc.size()), 64'(n0));

      // Back-to-back with cmd_valid held high.
      rise_cyc.delete();
      issue(2'b01, 5, rand40(), 1'b1, 1'b0, 1'b1);
      chk("ready_while_busy", 64'(bus.cmd_ready), 64'd0);
      chk("busy_flag", 64'(bus.busy), 64'd1);
      issue(2'b10, 12, rand40(), 1'b1, 1'b0, 1'b0);
      wait_idle();
      if (rise_cyc.size() >= 12)
         chk("b2b_gap_under_2_periods", 64'((rise_cyc[11] - rise_cyc[10]) < 4 * DIV), 64'd1);
      else
         fail_now("b2b_edge_count");

      // Reset in the middle of DR shift step 10.
      d = rand40();
      d[10] = 1'b0;
      rise_cyc.delete();
      issue(2'b10, 30, d, 1'b0, 1'b0, 1'b0);
      n = 0;
      while (rise_cyc.size() < 13 && n < 500) begin @(negedge clk); n++; end
      while (jtag_TCK !== 1'b0 && n < 500) begin @(negedge clk); n++; end
      if (n >= 500) fail_now("midscan_wait_timeout");
      chk("shift10_tms", 64'(jtag_TMS), 64'd0);
      chk("shift10_tdi", 64'(jtag_TDI), 64'd0);
      rst = 1'b0;
      rsp_q.delete();
      edge_q.delete();
      #1;
      chk("abort_tck", 64'(jtag_TCK), 64'd0);
      chk("abort_tms", 64'(jtag_TMS), 64'd1);
      chk("abort_tdi", 64'(jtag_TDI), 64'd1);
      chk("abort_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("abort_ready", 64'(bus.cmd_ready), 64'd1);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (150) @(negedge clk);
      chk("post_abort_ready", 64'(bus.cmd_ready), 64'd1);
      issue(2'b00, 0, '0, 1'b0, 1'b0, 1'b0);
      wait_idle();

      // Randomized mix, including invalid lengths and back-to-back issue.
      for (int i = 0; i < 30; i++) begin
         op  = 2'($urandom_range(0, 3));
         len = ($urandom_range(0, 5) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : 41 + int'($urandom_range(0, 22)))
                                           : int'($urandom_range(1, MAX_LEN));
         issue(op, len, rand40(), 1'($urandom), ($urandom_range(0, 7) == 0), (i != 29) && ($urandom_range(0, 2) == 0));
      end
      wait_idle();

      chk("edges_left", 64'(edge_q.size()), 64'd0);
      chk("rsp_left", 64'(rsp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
